fetch_sequencer: RTL and testbench

Instruction fetch sequencer that sits directly downstream of the three-phase clock generator. It consumes the rotating one-hot phase strobes (cycle, ram, internal) as clock enables on the single system clock. Each rotation it runs one fetch: it drives the program counter to memory, captures the returned word into the instruction register, and advances or branches the PC. It also implements the halt request and detects phase-sequence errors.

---
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_fetch_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one instruction fetch per rotation of the three-phase
// strobes (cycle -> ram -> internal). The strobes act as clock enables
// on the single system clock. The block also handles halt requests and
// flags phase-sequence errors.
module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cycle_en,
  input  logic              ram_en,
  input  logic              int_en,
  input  logic              halt,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              phase_err
);

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_UPD  = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic              halted_q;
  logic              phase_err_q;
  logic              multi_strobe;

  // The strobes are one-hot. Any two at once is a corrupted rotation.
  assign multi_strobe = (cycle_en & ram_en) | (cycle_en & int_en) | (ram_en & int_en);

  // Next PC: take the branch target, or step forward. Adding 1 to all-ones
  // wraps to 0.
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (branch_valid) pc_d = branch_addr;
  end

  // Fetch FSM with all outputs registered. ir_valid and phase_err are
  // single-clock pulses, so they default low on every edge.
  // NOTE: state uses non-blocking assignments only, so every branch reads the
  // values from before the edge. The reset is asynchronous, which lets
  // mem_rd drop without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ADDR;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      ir_valid_q  <= 1'b0;
      phase_err_q <= 1'b0;
      if (multi_strobe) begin
        // Flag the error and leave every other register untouched.
        phase_err_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_ADDR: begin
            // ram_en/int_en are ignored here so the block can align to the
            // rotation after reset.
            if (cycle_en) begin
              if (halt) begin
                halted_q <= 1'b1;
                state_q  <= HALT;
              end else begin
                mem_addr_q <= pc_q;
                mem_rd_q   <= 1'b1;
                state_q    <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (ram_en) begin
              ir_q     <= mem_rdata;
              mem_rd_q <= 1'b0;
              state_q  <= S_UPD;
            end else if (cycle_en || int_en) begin
              phase_err_q <= 1'b1;
              mem_rd_q    <= 1'b0;
              state_q     <= S_ADDR;
            end
          end
          S_UPD: begin
            if (int_en) begin
              pc_q       <= pc_d;
              ir_valid_q <= 1'b1;
              state_q    <= S_ADDR;
            end else if (cycle_en || ram_en) begin
              phase_err_q <= 1'b1;
              state_q     <= S_ADDR;
            end
          end
          HALT: begin
            // Resuming issues the fetch on the same edge that clears halted.
            if (cycle_en && !halt) begin
              halted_q   <= 1'b0;
              mem_addr_q <= pc_q;
              mem_rd_q   <= 1'b1;
              state_q    <= S_DATA;
            end
          end
          default: state_q <= S_ADDR;
        endcase
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign phase_err = phase_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. The stimulus is hand-written
// rotations, and every expected value is a hand-computed constant.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cycle_en, ram_en, int_en;
  logic       halt, branch_valid;
  logic [7:0] branch_addr, mem_rdata;
  logic [7:0] mem_addr, ir, pc;
  logic       mem_rd, ir_valid, halted, phase_err;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cycle_en     (cycle_en),
    .ram_en       (ram_en),
    .int_en       (int_en),
    .halt         (halt),
    .branch_valid (branch_valid),
    .branch_addr  (branch_addr),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .pc           (pc),
    .halted       (halted),
    .phase_err    (phase_err)
  );

  always #5 clk = ~clk;

  // Drive one clock with the given strobes, then sample 1 time unit after the edge.
  task automatic tick(input logic c, input logic r, input logic i);
    cycle_en = c; ram_en = r; int_en = i;
    @(posedge clk); #1;
    cycle_en = 1'b0; ram_en = 1'b0; int_en = 1'b0;
  endtask

  // One clean rotation: fetch exp_addr, memory returns rdata, and the PC update gives exp_pc.
  task automatic do_rotation(input logic [7:0] exp_addr, input logic [7:0] rdata,
                             input logic br_v, input logic [7:0] br_a,
                             input logic [7:0] exp_pc);
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rot_mem_rd_hi: got %b expected 1", mem_rd); end
    checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rot_mem_addr: got %h expected %h", mem_addr, exp_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rot_ir_valid_lo: got %b expected 0", ir_valid); end
    checks++; if (phase_err !== 1'b0) begin errors++; $display("FAIL rot_phase_err_lo: got %b expected 0", phase_err); end
    mem_rdata = rdata;
    tick(1'b0, 1'b1, 1'b0);
    mem_rdata = 8'h00;
    checks++; if (ir !== rdata) begin errors++; $display("FAIL rot_ir: got %h expected %h", ir, rdata); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rot_mem_rd_lo: got %b expected 0", mem_rd); end
    branch_valid = br_v; branch_addr = br_a;
    tick(1'b0, 1'b0, 1'b1);
    branch_valid = 1'b0; branch_addr = 8'h00;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rot_pc: got %h expected %h", pc, exp_pc); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL rot_ir_valid_hi: got %b expected 1", ir_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle_en = 1'b0; ram_en = 1'b0; int_en = 1'b0;
    halt = 1'b0; branch_valid = 1'b0; branch_addr = 8'h00; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h expected 00", ir); end
    checks++; if ({ir_valid, halted, phase_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ir_valid, halted, phase_err}); end
    reset = 1'b0;
  endtask

  // Reset is released mid-rotation, so ram_en and int_en arrive before cycle_en.
  task automatic test_align();
    tick(1'b0, 1'b1, 1'b0);
    checks++; if (phase_err !== 1'b0) begin errors++; $display("FAIL align_ram_err: got %b expected 0", phase_err); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL align_mem_rd: got %b expected 0", mem_rd); end
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (phase_err !== 1'b0) begin errors++; $display("FAIL align_int_err: got %b expected 0", phase_err); end
    checks++; if ({pc, ir_valid} !== {8'h00, 1'b0}) begin errors++; $display("FAIL align_pc: got %h/%b expected 00/0", pc, ir_valid); end
  endtask

  task automatic test_rotations();
    for (int k = 0; k < 4; k++)
      do_rotation(8'(k), 8'(8'h10 + k), 1'b0, 8'h00, 8'(k + 1));
  endtask

  task automatic test_branch();
    do_rotation(8'h04, 8'h20, 1'b0, 8'h00, 8'h05);
    do_rotation(8'h05, 8'h21, 1'b1, 8'h80, 8'h80);
    do_rotation(8'h80, 8'h22, 1'b0, 8'h00, 8'h81);
    do_rotation(8'h81, 8'h23, 1'b1, 8'hFF, 8'hFF);
    do_rotation(8'hFF, 8'h24, 1'b0, 8'h00, 8'h00);
    do_rotation(8'h00, 8'h25, 1'b1, 8'h05, 8'h05);
  endtask

  task automatic test_halt();
    halt = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++; if ({halted, mem_rd} !== 2'b10) begin errors++; $display("FAIL halt_cycle: got halted/mem_rd %b expected 10", {halted, mem_rd}); end
      mem_rdata = 8'hEE;
      tick(1'b0, 1'b1, 1'b0);
      mem_rdata = 8'h00;
      checks++; if ({mem_rd, ir} !== {1'b0, 8'h25}) begin errors++; $display("FAIL halt_ram: got %b/%h expected 0/25", mem_rd, ir); end
      branch_valid = 1'b1; branch_addr = 8'h99;
      tick(1'b0, 1'b0, 1'b1);
      branch_valid = 1'b0;
      checks++; if ({pc, ir_valid, phase_err} !== {8'h05, 2'b00}) begin errors++; $display("FAIL halt_int: got pc %h flags %b expected 05 00", pc, {ir_valid, phase_err}); end
    end
    halt = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    checks++; if ({halted, mem_rd} !== 2'b01) begin errors++; $display("FAIL resume_flags: got halted/mem_rd %b expected 01", {halted, mem_rd}); end
    checks++; if (mem_addr !== 8'h05) begin errors++; $display("FAIL resume_addr: got %h expected 05", mem_addr); end
    mem_rdata = 8'h44;
    tick(1'b0, 1'b1, 1'b0);
    mem_rdata = 8'h00;
    tick(1'b0, 1'b0, 1'b1);
    checks++; if ({pc, ir, ir_valid} !== {8'h06, 8'h44, 1'b1}) begin errors++; $display("FAIL resume_done: got %h/%h/%b expected 06/44/1", pc, ir, ir_valid); end
  endtask

  task automatic test_phase_error();
    tick(1'b1, 1'b0, 1'b0);
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 8'h06}) begin errors++; $display("FAIL perr_fetch: got %b/%h expected 1/06", mem_rd, mem_addr); end
    mem_rdata = 8'hBB;
    tick(1'b0, 1'b0, 1'b0);
    mem_rdata = 8'h00;
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (phase_err !== 1'b1) begin errors++; $display("FAIL perr_pulse: got %b expected 1", phase_err); end
    checks++; if ({pc, ir, mem_rd, ir_valid} !== {8'h06, 8'h44, 2'b00}) begin errors++; $display("FAIL perr_state: got %h/%h/%b expected 06/44/00", pc, ir, {mem_rd, ir_valid}); end
    do_rotation(8'h06, 8'h55, 1'b0, 8'h00, 8'h07);
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 1'b0);
    checks++; if ({mem_rd, pc} !== {1'b1, 8'h07}) begin errors++; $display("FAIL areset_pre: got %b/%h expected 1/07", mem_rd, pc); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({mem_rd, pc, ir, mem_addr} !== {1'b0, 24'h0}) begin errors++; $display("FAIL areset_clear: got mem_rd %b pc %h ir %h addr %h expected 0 00 00 00", mem_rd, pc, ir, mem_addr); end
    #1 reset = 1'b0;
    // Two strobes together while in S_DATA: only phase_err changes.
    tick(1'b1, 1'b0, 1'b0);
    mem_rdata = 8'hCC;
    tick(1'b1, 1'b1, 1'b0);
    checks++; if (phase_err !== 1'b1) begin errors++; $display("FAIL multi_pulse: got %b expected 1", phase_err); end
    checks++; if ({mem_rd, mem_addr, ir, ir_valid} !== {1'b1, 8'h00, 8'h00, 1'b0}) begin errors++; $display("FAIL multi_hold: got %b/%h/%h/%b expected 1/00/00/0", mem_rd, mem_addr, ir, ir_valid); end
    mem_rdata = 8'h5A;
    tick(1'b0, 1'b1, 1'b0);
    mem_rdata = 8'h00;
    checks++; if ({ir, phase_err, mem_rd} !== {8'h5A, 2'b00}) begin errors++; $display("FAIL multi_resume: got %h/%b expected 5A/00", ir, {phase_err, mem_rd}); end
    tick(1'b0, 1'b0, 1'b1);
    checks++; if ({pc, ir_valid} !== {8'h01, 1'b1}) begin errors++; $display("FAIL multi_done: got %h/%b expected 01/1", pc, ir_valid); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_rotations();
    test_branch();
    test_halt();
    test_phase_error();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
